// File: rtl/dsc_mul_seq.sv
// rtl/dsc_mul_seq.sv - requester-side sequencer for one dsc_mul instance (optional self-check: DSC_MUL_SEQ_CHECK_EN)
module dsc_mul_seq #(
    parameter int WIDTH      = 6,
    parameter int Z_WIDTH    = 2 * WIDTH,
    parameter int CNT_WIDTH  = 16,
    parameter int MAX_CYCLES = 4096 + 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Z_WIDTH-1:0]   out_z,
    output logic [CNT_WIDTH-1:0] out_cycles,
    output logic                 out_timeout,
    output logic                 out_err,
    output logic                 mul_rst,
    output logic                 mul_en,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [Z_WIDTH-1:0]   mul_z,
    input  logic                 mul_ov
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 accept;
    logic                 capture;
    logic                 timeout_nxt;
    logic                 cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        mul_rst     = 1'b1;
        mul_en      = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_nxt = 1'b0;
        unique case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                mul_rst = 1'b0;
                mul_en  = 1'b1;
                // completion is checked first so ov on the limit cycle is not a timeout
                if (mul_ov) begin
                    capture   = 1'b1;
                    state_nxt = S_DONE;
                end else if (cnt == CNT_WIDTH'(MAX_CYCLES)) begin
                    capture     = 1'b1;
                    timeout_nxt = 1'b1;
                    state_nxt   = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // counting through CLEAR makes the first RUN cycle read 1
    assign cnt_inc = ((state == S_CLEAR) || ((state == S_RUN) && !capture))
                     && (cnt != {CNT_WIDTH{1'b1}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            mul_a       <= '0;
            mul_b       <= '0;
            out_z       <= '0;
            out_cycles  <= '0;
            out_timeout <= 1'b0;
        end else begin
            if (accept) begin
                mul_a <= in_a;
                mul_b <= in_b;
                cnt   <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + CNT_WIDTH'(1);
            end
            if (capture) begin
                out_z       <= mul_z;
                out_cycles  <= cnt;
                out_timeout <= timeout_nxt;
            end
        end
    end

`ifdef DSC_MUL_SEQ_CHECK_EN
    logic [Z_WIDTH-1:0] expected;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
            out_err  <= 1'b0;
        end else begin
            if (state == S_CLEAR) begin
                expected <= Z_WIDTH'(mul_a) * Z_WIDTH'(mul_b);
            end
            if (capture) begin
                out_err <= (mul_z != expected) | timeout_nxt;
            end
        end
    end
`else
    assign out_err = 1'b0;
`endif

endmodule

// File: doc/dsc_mul_seq.md
# dsc_mul_seq

Requester-side sequencer for the deterministic stochastic-computing multiplier (`dsc_mul`). It accepts operand pairs over a valid/ready input channel and drives the multiplier's `rst`/`en`/`a`/`b` inputs. It waits for the multiplier's `ov` completion flag, then returns the product `z` and the measured cycle count over a valid/ready output channel. It sits between an operand source (host or DMA) and one `dsc_mul` instance, and it is the synthesizable form of the drive/clear/wait/capture sequence used at block level.

## Interface
Parameters:
- `WIDTH`, 6, operand width of `a` and `b`
- `Z_WIDTH`, 2*WIDTH, product width
- `CNT_WIDTH`, 16, cycle counter width
- `MAX_CYCLES`, 4096 + 16, RUN-cycle limit before timeout; must be < 2^CNT_WIDTH

Ports:
- `clk` in 1: single clock; all logic rising-edge
- `rst_n` in 1: asynchronous, active-low reset
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: sequencer can accept an operand pair
- `in_a` in WIDTH: operand a
- `in_b` in WIDTH: operand b
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `out_z` out Z_WIDTH: captured product
- `out_cycles` out CNT_WIDTH: RUN cycles until completion
- `out_timeout` out 1: completion forced by MAX_CYCLES
- `out_err` out 1: self-check mismatch (see Configuration)
- `mul_rst` out 1: active-high reset to `dsc_mul`
- `mul_en` out 1: enable to `dsc_mul`
- `mul_a` out WIDTH: registered operand a to `dsc_mul`
- `mul_b` out WIDTH: registered operand b to `dsc_mul`
- `mul_z` in Z_WIDTH: product from `dsc_mul`
- `mul_ov` in 1: completion flag from `dsc_mul`

## Operation
- The FSM has four states: IDLE, CLEAR, RUN and DONE. Outputs are decoded from registered state.
- IDLE:
  - Drives `in_ready`=1, `mul_rst`=1, `mul_en`=0.
  - On `in_valid & in_ready`, latches `in_a`/`in_b` into `mul_a`/`mul_b`, clears the cycle counter, and goes to CLEAR.
- CLEAR: lasts exactly one cycle. Drives `mul_rst`=1 and `mul_en`=0 with the new operands already stable, then goes to RUN.
- RUN:
  - Drives `mul_rst`=0 and `mul_en`=1.
  - The counter increments once per RUN cycle; its value in the first RUN cycle is 1.
  - If `mul_ov`=1 is sampled: capture `mul_z` into `out_z` and the counter into `out_cycles`, set `out_timeout`=0, and go to DONE.
  - Else, if the counter equals MAX_CYCLES: capture `mul_z` and the counter, set `out_timeout`=1, and go to DONE.
- DONE:
  - Drives `out_valid`=1, `mul_rst`=1, `mul_en`=0.
  - On `out_valid & out_ready`, goes to IDLE.
  - `out_z`, `out_cycles`, `out_timeout` and `out_err` hold until the next capture.
- Arithmetic: the counter saturates at 2^CNT_WIDTH−1 and never wraps. `out_z` is a direct copy of `mul_z` with no re-scaling.

## Timing
- Reset values (asynchronous on `rst_n`=0):
  - State is IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `out_z`, `out_cycles`, `out_timeout`, `out_err`, `mul_a`, `mul_b` are all 0.
  - `mul_rst`=1, `mul_en`=0.
- Latency from accept edge:
  - 1 cycle in CLEAR, then N RUN cycles, where N is the cycle on which `mul_ov` is first sampled high.
  - `out_valid` rises on the edge after that sample.
  - Total latency is N+2 cycles from accept to `out_valid`.
- Handshakes:
  - `in_ready` is low in CLEAR, RUN and DONE.
  - No new accept is possible in the cycle that DONE retires. The earliest accept is the cycle after `out_ready` is taken.
  - `out_valid` never drops without `out_ready`.
- Simultaneous events:
  - `mul_ov`=1 on the cycle the counter reaches MAX_CYCLES: completion wins and `out_timeout`=0.
  - `mul_ov` high in IDLE, CLEAR or DONE is ignored.
- Reset mid-operation: `rst_n` low in any state immediately forces `mul_rst`=1, `mul_en`=0, `out_valid`=0 and IDLE. Any result in flight is discarded.

## Configuration
- `DSC_MUL_SEQ_CHECK_EN` defined:
  - In CLEAR, the block registers `expected = mul_a * mul_b` (Z_WIDTH bits).
  - At capture, `out_err` = (`mul_z` != `expected`) | timeout, held with the result.
  - Adds one WIDTH×WIDTH multiplier.
- Not defined: `out_err` is tied to 0 and no multiplier is instantiated.

## Test plan
- Reset: `rst_n`=0 for 3 cycles, then 1 → `in_ready`=1, `out_valid`=0, `mul_rst`=1, `mul_en`=0, and all data outputs are 0.
- Nominal: accept a=15, b=15; the multiplier model raises `mul_ov` on RUN cycle 4096 with `mul_z`=225 → `out_valid` 4098 cycles after accept, `out_z`=225, `out_cycles`=4096, `out_timeout`=0, `out_err`=0.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `out_valid`, `out_z` and `out_cycles` stay stable, `in_ready`=0 throughout, and the next accept happens the cycle after `out_ready`=1.
- Timeout: the model never raises `mul_ov` → after 4112 RUN cycles, `out_valid`=1, `out_timeout`=1, `out_cycles`=4112, and `out_err`=1 if `DSC_MUL_SEQ_CHECK_EN` is defined.
- Self-check: a=15, b=15, model returns `mul_z`=224 → `out_err`=1 with `DSC_MUL_SEQ_CHECK_EN` defined and `out_err`=0 without it.
- Mid-run reset: assert `rst_n`=0 at RUN cycle 100 → `mul_en`=0 and `mul_rst`=1 within the same cycle, no `out_valid`; after release, a new pair a=3, b=5 completes with `out_z`=15.
